// File: rtl/fe_pkg.sv
// Fetch front-end shared defaults and the {pc,insn} buffer entry layout.
package fe_pkg;
    localparam int unsigned FE_PC_WIDTH   = 16;
    localparam int unsigned FE_INSN_WIDTH = 40;
    localparam int unsigned FE_RESET_PC   = 0;

    typedef struct packed {
        logic [FE_PC_WIDTH-1:0]   pc;
        logic [FE_INSN_WIDTH-1:0] insn;
    } fe_entry_t;

    function automatic int unsigned fe_entry_width(input int unsigned pc_w, input int unsigned insn_w);
        return pc_w + insn_w;
    endfunction
endpackage

// File: rtl/fe_sync_fifo.sv
// Synchronous FIFO with flush; the head is presented straight from storage, zero when empty.
module fe_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC issue, in-order variable-latency responses,
// credit-checked decoupling buffer to decode, redirect flush with in-flight response drop.
module fetch_unit
    import fe_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = FE_PC_WIDTH,
    parameter int unsigned INSN_WIDTH = FE_INSN_WIDTH,
    parameter int unsigned PC_STEP    = 1,
    parameter int unsigned RESET_PC   = FE_RESET_PC,
    parameter int unsigned BUF_DEPTH  = 4,
    parameter int unsigned MAX_OUTST  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [PC_WIDTH-1:0]   imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INSN_WIDTH-1:0] imem_rsp_data,
    output logic                  insn_valid,
    input  logic                  insn_ready,
    output logic [INSN_WIDTH-1:0] insn,
    output logic [PC_WIDTH-1:0]   insn_pc
);
    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned OW = $clog2(MAX_OUTST) + 1;
    localparam int unsigned SW = CW + OW;
    localparam int unsigned EW = fe_entry_width(PC_WIDTH, INSN_WIDTH);
    localparam logic [PC_WIDTH-1:0] PC_RST = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] PC_INC = PC_WIDTH'(PC_STEP);

    logic                reset_q;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] rsp_pc;
    logic [OW-1:0]       outst;
    logic [OW-1:0]       drop;
    logic [OW-1:0]       outst_next;
    logic [CW-1:0]       count;
    logic [SW-1:0]       live;
    logic                accept;
    logic                push;
    logic                pop;
    logic                buf_full;
    logic                buf_empty;
    logic [EW-1:0]       head;

    // Requests still owed data after dropping occupy a buffer slot each.
    assign live           = SW'(count) + SW'(outst) - SW'(drop);
    assign imem_req_valid = !reset_q && !redirect_valid
                            && (outst < OW'(MAX_OUTST)) && (live < SW'(BUF_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign push           = imem_rsp_valid && (drop == '0) && !redirect_valid;
    assign pop            = insn_valid && insn_ready;
    assign outst_next     = outst + OW'(accept) - OW'(imem_rsp_valid);

    assign insn_valid       = !buf_empty;
    assign {insn_pc, insn}  = head;

    always_ff @(posedge clk) begin
        reset_q <= reset;
        if (reset) begin
            fetch_pc <= PC_RST;
            rsp_pc   <= PC_RST;
            outst    <= '0;
            drop     <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            rsp_pc   <= redirect_pc;
            outst    <= outst_next;
            drop     <= outst_next;
        end else begin
            if (accept) fetch_pc <= fetch_pc + PC_INC;
            if (push)   rsp_pc   <= rsp_pc + PC_INC;
            outst <= outst_next;
            if (imem_rsp_valid && drop != '0) drop <= drop - 1'b1;
        end
    end

    fe_sync_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (EW)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({rsp_pc, imem_rsp_data}),
        .pop       (pop),
        .pop_data  (head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (count)
    );

    rsp_needs_req: assert property (@(posedge clk) disable iff (reset)
        imem_rsp_valid |-> (outst != '0));
    no_push_full: assert property (@(posedge clk) disable iff (reset)
        push |-> (!buf_full || pop));

`ifdef FE_TRACE
    always_ff @(posedge clk) begin
        if (!reset && accept) $display("Fetching pc:%h", fetch_pc);
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: responsive memory model plus a fetch-stream reference.
module tb_fetch_unit;
    localparam int unsigned PCW = 16;
    localparam int unsigned IW  = 40;

    logic           clk;
    logic           reset;
    logic           redirect_valid;
    logic [PCW-1:0] redirect_pc;
    logic           imem_req_valid;
    logic           imem_req_ready;
    logic [PCW-1:0] imem_req_addr;
    logic           imem_rsp_valid;
    logic [IW-1:0]  imem_rsp_data;
    logic           insn_valid;
    logic           insn_ready;
    logic [IW-1:0]  insn;
    logic [PCW-1:0] insn_pc;

    fetch_unit #(
        .PC_WIDTH   (16),
        .INSN_WIDTH (40),
        .PC_STEP    (1),
        .RESET_PC   (0),
        .BUF_DEPTH  (4),
        .MAX_OUTST  (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .insn_valid     (insn_valid),
        .insn_ready     (insn_ready),
        .insn           (insn),
        .insn_pc        (insn_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_pass;

    // Memory model: in-order queue of accepted requests, each with a due cycle.
    typedef struct {
        logic [PCW-1:0] addr;
        int unsigned    due;
    } pend_t;
    pend_t       pq[$];
    int unsigned cyc;
    int unsigned resp_cnt;
    int unsigned lat_min   = 1;
    int unsigned lat_max   = 1;
    int unsigned ready_pct = 100;

    function automatic logic [IW-1:0] mkdata(input logic [PCW-1:0] a);
        return {8'hC3, a, a ^ 16'h5A5A};
    endfunction

    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        cyc      = 0;
        resp_cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            imem_req_ready = ($urandom_range(0, 99) < ready_pct);
            if (!reset && pq.size() != 0 && pq[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mkdata(pq[0].addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = IW'({$urandom(), $urandom()});
            end
            #1;
            if (reset) begin
                pq.delete();
            end else begin
                if (imem_rsp_valid) begin
                    pq.delete(0);
                    resp_cnt++;
                end
                if (imem_req_valid && imem_req_ready)
                    pq.push_back('{addr: imem_req_addr, due: cyc + $urandom_range(lat_min, lat_max)});
            end
            cyc++;
        end
    end

    // Snapshot of the cycle, taken just before the active edge.
    logic           s_acc, s_pop, s_rqv, s_iv;
    logic [PCW-1:0] s_addr, s_pc;
    logic [IW-1:0]  s_insn;
    // Reference stream: next expected request address and next expected delivered pc.
    logic [PCW-1:0] exp_req, exp_pop;

    task automatic step(input logic rst, input logic redir, input logic [PCW-1:0] rpc, input logic rdy);
        @(negedge clk);
        reset          = rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        insn_ready     = rdy;
        #3;
        s_rqv  = imem_req_valid;
        s_acc  = imem_req_valid && imem_req_ready;
        s_addr = imem_req_addr;
        s_iv   = insn_valid;
        s_pop  = insn_valid && rdy;
        s_pc   = insn_pc;
        s_insn = insn;
    endtask

    task automatic model_edge(input logic rst, input logic redir, input logic [PCW-1:0] rpc);
        if (rst) begin
            exp_req = 16'h0000;
            exp_pop = 16'h0000;
        end else if (redir) begin
            exp_req = rpc;
            exp_pop = rpc;
        end else begin
            if (s_acc) exp_req++;
            if (s_pop) exp_pop++;
        end
    endtask

    task automatic apply_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        model_edge(1'b1, 1'b0, '0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        n_checks++;
        if ({s_rqv, s_iv} !== 2'b00) $display("FAIL reset_valids: got req/insn %b%b want 00", s_rqv, s_iv);
        else n_pass++;
        n_checks++;
        if (s_addr !== 16'h0000) $display("FAIL reset_addr: got %h want 0000", s_addr);
        else n_pass++;
        n_checks++;
        if ({s_pc, s_insn} !== 56'h0) $display("FAIL reset_head: got pc %h insn %h want 0", s_pc, s_insn);
        else n_pass++;
        model_edge(1'b1, 1'b0, '0);
    endtask

    task automatic test_stream();
        int unsigned late_pops;
        late_pops = 0;
        lat_min = 1; lat_max = 1; ready_pct = 100;
        apply_reset();
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            if (s_acc) begin
                n_checks++;
                if (s_addr !== exp_req) $display("FAIL stream_addr: got %h want %h", s_addr, exp_req);
                else n_pass++;
            end
            if (s_pop) begin
                n_checks++;
                if ({s_pc, s_insn} !== {exp_pop, mkdata(exp_pop)})
                    $display("FAIL stream_insn: got pc %h insn %h want pc %h insn %h", s_pc, s_insn, exp_pop, mkdata(exp_pop));
                else n_pass++;
                if (i >= 10) late_pops++;
            end
            model_edge(1'b0, 1'b0, '0);
        end
        n_checks++;
        if (late_pops != 20) $display("FAIL stream_rate: got %0d insns in 20 cycles want 20", late_pops);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int unsigned accepted;
        int unsigned pops;
        accepted = 0;
        pops     = 0;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            if (s_acc) begin
                accepted++;
                n_checks++;
                if (s_addr !== exp_req) $display("FAIL bp_addr: got %h want %h", s_addr, exp_req);
                else n_pass++;
            end
            model_edge(1'b0, 1'b0, '0);
        end
        n_checks++;
        if (accepted != 4) $display("FAIL bp_accepted: got %0d want 4", accepted);
        else n_pass++;
        n_checks++;
        if ({s_iv, s_rqv, s_pc} !== {1'b1, 1'b0, 16'h0000})
            $display("FAIL bp_stalled: got valid %b req %b pc %h want 1 0 0000", s_iv, s_rqv, s_pc);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            if (s_acc) begin
                n_checks++;
                if (s_addr !== exp_req) $display("FAIL bp_resume_addr: got %h want %h", s_addr, exp_req);
                else n_pass++;
            end
            if (s_pop) begin
                pops++;
                n_checks++;
                if ({s_pc, s_insn} !== {exp_pop, mkdata(exp_pop)})
                    $display("FAIL bp_drain: got pc %h insn %h want pc %h", s_pc, s_insn, exp_pop);
                else n_pass++;
            end
            model_edge(1'b0, 1'b0, '0);
        end
        n_checks++;
        if (pops < 4) $display("FAIL bp_drain_count: got %0d want >=4", pops);
        else n_pass++;
    endtask

    task automatic test_redirect_drop();
        int unsigned n;
        int unsigned pops;
        n    = 0;
        pops = 0;
        lat_min = 3; lat_max = 3;
        apply_reset();
        while (pq.size() < 2 && n < 20) begin
            step(1'b0, 1'b0, '0, 1'b1);
            model_edge(1'b0, 1'b0, '0);
            n++;
        end
        n_checks++;
        if (pq.size() != 2) $display("FAIL rd_inflight: got %0d in flight want 2 (timeout)", pq.size());
        else n_pass++;
        step(1'b0, 1'b1, 16'h0080, 1'b1);
        n_checks++;
        if (s_rqv !== 1'b0) $display("FAIL rd_noreq1: got req_valid %b want 0", s_rqv);
        else n_pass++;
        model_edge(1'b0, 1'b1, 16'h0080);
        step(1'b0, 1'b1, 16'h0100, 1'b1);
        n_checks++;
        if (s_rqv !== 1'b0) $display("FAIL rd_noreq2: got req_valid %b want 0", s_rqv);
        else n_pass++;
        model_edge(1'b0, 1'b1, 16'h0100);
        step(1'b0, 1'b0, '0, 1'b1);
        n_checks++;
        if ({s_acc, s_addr, s_iv} !== {1'b1, 16'h0100, 1'b0})
            $display("FAIL rd_first_req: got acc %b addr %h valid %b want 1 0100 0", s_acc, s_addr, s_iv);
        else n_pass++;
        model_edge(1'b0, 1'b0, '0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            if (s_acc) begin
                n_checks++;
                if (s_addr !== exp_req) $display("FAIL rd_addr: got %h want %h", s_addr, exp_req);
                else n_pass++;
            end
            if (s_pop) begin
                pops++;
                n_checks++;
                if ({s_pc, s_insn} !== {exp_pop, mkdata(exp_pop)})
                    $display("FAIL rd_insn: got pc %h insn %h want pc %h", s_pc, s_insn, exp_pop);
                else n_pass++;
            end
            model_edge(1'b0, 1'b0, '0);
        end
        n_checks++;
        if (pops == 0) $display("FAIL rd_delivered: got 0 insns want >0");
        else n_pass++;
    endtask

    task automatic test_redirect_full();
        int unsigned n;
        int unsigned base;
        n = 0;
        lat_min = 3; lat_max = 3;
        apply_reset();
        base = resp_cnt;
        // Fill with decode stalled until a response is due next cycle onto three buffered entries.
        while (!((resp_cnt - base) == 3 && pq.size() != 0 && pq[0].due <= cyc) && n < 40) begin
            step(1'b0, 1'b0, '0, 1'b0);
            model_edge(1'b0, 1'b0, '0);
            n++;
        end
        n_checks++;
        if (n >= 40) $display("FAIL rf_setup: got timeout want response pending on 3 buffered");
        else n_pass++;
        step(1'b0, 1'b1, 16'h0200, 1'b1);
        n_checks++;
        if ({s_iv, s_pc} !== {1'b1, 16'h0000}) $display("FAIL rf_head: got valid %b pc %h want 1 0000", s_iv, s_pc);
        else n_pass++;
        model_edge(1'b0, 1'b1, 16'h0200);
        step(1'b0, 1'b0, '0, 1'b1);
        n_checks++;
        if ({s_iv, s_acc, s_addr} !== {1'b0, 1'b1, 16'h0200})
            $display("FAIL rf_after: got valid %b acc %b addr %h want 0 1 0200", s_iv, s_acc, s_addr);
        else n_pass++;
        model_edge(1'b0, 1'b0, '0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            if (s_acc) begin
                n_checks++;
                if (s_addr !== exp_req) $display("FAIL rf_addr: got %h want %h", s_addr, exp_req);
                else n_pass++;
            end
            if (s_pop) begin
                n_checks++;
                if ({s_pc, s_insn} !== {exp_pop, mkdata(exp_pop)})
                    $display("FAIL rf_insn: got pc %h insn %h want pc %h", s_pc, s_insn, exp_pop);
                else n_pass++;
            end
            model_edge(1'b0, 1'b0, '0);
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [PCW-1:0] addrs[$];
        int unsigned    n;
        int unsigned    pops;
        n    = 0;
        pops = 0;
        lat_min = 1; lat_max = 1;
        apply_reset();
        step(1'b0, 1'b1, 16'hFFFF, 1'b1);
        model_edge(1'b0, 1'b1, 16'hFFFF);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            if (s_acc) addrs.push_back(s_addr);
            if (s_pop) begin
                n_checks++;
                if ({s_pc, s_insn} !== {exp_pop, mkdata(exp_pop)})
                    $display("FAIL wrap_insn: got pc %h want pc %h", s_pc, exp_pop);
                else n_pass++;
            end
            model_edge(1'b0, 1'b0, '0);
        end
        n_checks++;
        if (addrs.size() < 2 || addrs[0] !== 16'hFFFF || addrs[1] !== 16'h0000)
            $display("FAIL wrap_addr: got %0d reqs first %h %h want FFFF 0000", addrs.size(),
                     (addrs.size() > 0) ? addrs[0] : 16'hxxxx, (addrs.size() > 1) ? addrs[1] : 16'hxxxx);
        else n_pass++;
        lat_min = 3; lat_max = 3;
        while (pq.size() == 0 && n < 20) begin
            step(1'b0, 1'b0, '0, 1'b0);
            model_edge(1'b0, 1'b0, '0);
            n++;
        end
        step(1'b1, 1'b0, '0, 1'b1);
        model_edge(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b1);
        n_checks++;
        if ({s_rqv, s_iv, s_addr, s_pc, s_insn} !== {1'b0, 1'b0, 16'h0000, 16'h0000, 40'h0})
            $display("FAIL midflight_reset: got req %b valid %b addr %h pc %h insn %h want all 0",
                     s_rqv, s_iv, s_addr, s_pc, s_insn);
        else n_pass++;
        model_edge(1'b0, 1'b0, '0);
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            if (s_acc) begin
                n_checks++;
                if (s_addr !== exp_req) $display("FAIL post_reset_addr: got %h want %h", s_addr, exp_req);
                else n_pass++;
            end
            if (s_pop) begin
                pops++;
                n_checks++;
                if ({s_pc, s_insn} !== {exp_pop, mkdata(exp_pop)})
                    $display("FAIL post_reset_insn: got pc %h want pc %h", s_pc, exp_pop);
                else n_pass++;
            end
            model_edge(1'b0, 1'b0, '0);
        end
        n_checks++;
        if (pops == 0) $display("FAIL post_reset_delivered: got 0 insns want >0");
        else n_pass++;
    endtask

    task automatic test_random();
        logic           redir, rdy, prev_redir;
        logic [PCW-1:0] rpc;
        int unsigned    pops;
        pops       = 0;
        prev_redir = 1'b0;
        lat_min = 1; lat_max = 4; ready_pct = 70;
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            redir = ($urandom_range(0, 99) < 4);
            rpc   = PCW'($urandom());
            rdy   = ($urandom_range(0, 99) < 75);
            step(1'b0, redir, rpc, rdy);
            if (redir) begin
                n_checks++;
                if (s_rqv !== 1'b0) $display("FAIL rnd_redirect_req: got req_valid %b want 0", s_rqv);
                else n_pass++;
            end
            if (prev_redir) begin
                n_checks++;
                if (s_iv !== 1'b0) $display("FAIL rnd_flush: got insn_valid %b want 0", s_iv);
                else n_pass++;
            end
            if (s_acc) begin
                n_checks++;
                if (s_addr !== exp_req) $display("FAIL rnd_addr: got %h want %h", s_addr, exp_req);
                else n_pass++;
            end
            if (s_pop && !redir) begin
                pops++;
                n_checks++;
                if ({s_pc, s_insn} !== {exp_pop, mkdata(exp_pop)})
                    $display("FAIL rnd_insn: got pc %h insn %h want pc %h insn %h", s_pc, s_insn, exp_pop, mkdata(exp_pop));
                else n_pass++;
            end
            model_edge(1'b0, redir, rpc);
            prev_redir = redir;
        end
        n_checks++;
        if (pops < 100) $display("FAIL rnd_progress: got %0d insns want >=100", pops);
        else n_pass++;
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        insn_ready     = 1'b0;
        n_checks       = 0;
        n_pass         = 0;
        exp_req        = '0;
        exp_pop        = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_full();
        test_wrap_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion by 1ms want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
